seven_segment_scanner: RTL
==========================

# seven_segment_scanner

Time-multiplexed two-digit display controller that drives a shared 7-segment bus from a 5-bit value (0–31). It latches the value and instantiates `seven_segment` to split it into tens and ones patterns. A scan FSM then alternates the two digit enables, with dead-time between digits to prevent ghosting. It sits between the game/score logic and the board's common-segment display pins.

## Interface
- `REFRESH_DIV`, default 1000: clock cycles each digit is lit; minimum 1.
- `DEAD_CYCLES`, default 16: blank cycles between digits; minimum 1.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `number`  in  5  value to display, 0–31.
- `load`  in  1  when high at a clock edge, capture `number`.
- `blank`  in  1  when high, force both digit enables low; scanning continues.
- `seg`  out  7  segment pattern, passed unchanged from `seven_segment`.
- `digit_en`  out  2  active-high digit enables: bit 1 is tens, bit 0 is ones. At most one bit is high.
- `frame_done`  out  1  one-cycle pulse at the end of each full tens/ones frame.

## Operation
- Registers:
  - `disp` (5b): drives `seven_segment.number`.
  - `shadow` (5b) and `pending`: hold a load that arrives mid-scan.
  - `blank_q`: registered copy of `blank`.
  - `cnt`: phase counter, wide enough for max(`REFRESH_DIV`, `DEAD_CYCLES`).
- FSM states: IDLE, TENS, GAP_T, ONES, GAP_O.
- IDLE:
  - `digit_en`=00, `seg`=`tens_digit` of `disp`.
  - On `load`: `disp`<=`number`, go to TENS, `cnt`<=0.
- TENS:
  - `digit_en`=10 (unless blanked), `seg`=`tens_digit`.
  - After `REFRESH_DIV` cycles, go to GAP_T.
- GAP_T:
  - `digit_en`=00, `seg`=`ones_digit`; the segments pre-settle while dark.
  - After `DEAD_CYCLES` cycles, go to ONES.
- ONES:
  - `digit_en`=01 (unless blanked), `seg`=`ones_digit`.
  - After `REFRESH_DIV` cycles, go to GAP_O.
- GAP_O:
  - `digit_en`=00, `seg`=`tens_digit`.
  - After `DEAD_CYCLES` cycles, go to TENS.
  - On that transition: pulse `frame_done`; if `pending`, `disp`<=`shadow` and `pending`<=0.
- `load` outside IDLE: `shadow`<=`number`, `pending`<=1. A later load before transfer overwrites `shadow` (last value wins).
- `load` on the same edge as GAP_O→TENS: `number` goes straight into `disp`, bypassing `shadow`; `pending` ends at 0.
- The displayed value changes only at frame boundaries, never mid-frame (no tearing).
- `digit_en` = state decode AND NOT `blank_q`. `blank` does not affect the FSM or `frame_done`.
- Values 30–31 are shown with whatever patterns `seven_segment` produces; no clamping.

## Timing
- Reset values:
  - State IDLE; `cnt`=0; `disp`=0; `shadow`=0; `pending`=0; `blank_q`=0.
  - Outputs: `digit_en`=00, `frame_done`=0, `seg`=`seven_segment` tens pattern for 0.
- All outputs are decoded from registers only; there is no combinational path from any input to any output.
- Load in IDLE sampled at edge N: `digit_en`=10 from edge N+1.
- Each lit phase lasts exactly `REFRESH_DIV` cycles; each gap lasts exactly `DEAD_CYCLES` cycles.
- Frame period = 2·(`REFRESH_DIV`+`DEAD_CYCLES`) cycles.
- `frame_done` is high during the first cycle of each TENS phase except the first one after IDLE.
- `blank` sampled at edge N affects `digit_en` from edge N+1.
- Reset asserted mid-scan: all outputs go to reset values immediately, asynchronously. Any pending load is lost.
- After reset releases, the block stays in IDLE until the next `load`.

## Configuration
- `SEVEN_SEGMENT_SCANNER_LZS_EN` defined (leading-zero suppression):
  - In TENS, `digit_en[1]` stays 0 when `disp` < 10.
  - TENS still lasts `REFRESH_DIV` cycles, so frame timing is unchanged.
- Not defined: the tens digit is always lit in TENS, including a displayed zero.

## Test plan
Bench parameters: `REFRESH_DIV`=4, `DEAD_CYCLES`=2, frame = 12 cycles.

- Reset, no load for 50 cycles -> `digit_en`=00 and `frame_done`=0 throughout; IDLE held.
- Load 23 -> next cycle `digit_en`=10 with `seg`=tens("2") for 4 cycles; then 00 for 2 cycles; then 01 with `seg`=ones("3") for 4 cycles; then 00 for 2 cycles; `frame_done` pulses at cycle 13; pattern repeats.
- Load 7 while in ONES, then load 19 two cycles later -> current frame keeps showing 23; from the next TENS phase the display shows 19; 7 never appears.
- `blank` high for 20 cycles mid-scan -> `digit_en`=00 from one cycle after `blank` is sampled; `frame_done` still pulses every 12 cycles; enables resume in the correct phase.
- Reset asserted during GAP_T -> `digit_en`=00 immediately; display stays dark until the next load; value restarts from `disp`=0.
- With `SEVEN_SEGMENT_SCANNER_LZS_EN` defined, load 5 -> `digit_en[1]` never high, ones lit 4 of every 12 cycles; load 10 -> tens digit lit again.

Source files
------------

// File: rtl/seven_segment_scanner.sv
// Two-digit multiplexed 7-segment driver with dead-time between digits and frame-aligned value updates.
// Optional leading-zero suppression of the tens digit: define SEVEN_SEGMENT_SCANNER_LZS_EN.

module seven_segment (
  input  logic [4:0] number,
  output logic [6:0] tens_digit,
  output logic [6:0] ones_digit
);

  logic [3:0] tens_val;
  logic [3:0] ones_val;

  // Segment order is {g,f,e,d,c,b,a}, active high.
  function automatic logic [6:0] encode(input logic [3:0] d);
    case (d)
      4'd0:    encode = 7'h3F;
      4'd1:    encode = 7'h06;
      4'd2:    encode = 7'h5B;
      4'd3:    encode = 7'h4F;
      4'd4:    encode = 7'h66;
      4'd5:    encode = 7'h6D;
      4'd6:    encode = 7'h7D;
      4'd7:    encode = 7'h07;
      4'd8:    encode = 7'h7F;
      4'd9:    encode = 7'h6F;
      default: encode = 7'h00;
    endcase
  endfunction

  always_comb begin
    if (number >= 5'd30) begin
      tens_val = 4'd3;
      ones_val = 4'(number - 5'd30);
    end else if (number >= 5'd20) begin
      tens_val = 4'd2;
      ones_val = 4'(number - 5'd20);
    end else if (number >= 5'd10) begin
      tens_val = 4'd1;
      ones_val = 4'(number - 5'd10);
    end else begin
      tens_val = 4'd0;
      ones_val = 4'(number);
    end
  end

  assign tens_digit = encode(tens_val);
  assign ones_digit = encode(ones_val);

endmodule

module seven_segment_scanner #(
  parameter int REFRESH_DIV = 1000,
  parameter int DEAD_CYCLES = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] number,
  input  logic       load,
  input  logic       blank,
  output logic [6:0] seg,
  output logic [1:0] digit_en,
  output logic       frame_done
);

  localparam int CNT_MAX = (REFRESH_DIV > DEAD_CYCLES) ? REFRESH_DIV : DEAD_CYCLES;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CW-1:0] LIT_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(DEAD_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, TENS, GAP_T, ONES, GAP_O} state_t;

  state_t        state;
  state_t        state_next;
  logic [CW-1:0] cnt;
  logic [4:0]    disp;
  logic [4:0]    shadow;
  logic          pending;
  logic          blank_q;
  logic          phase_last;
  logic          frame_edge;
  logic [6:0]    tens_seg;
  logic [6:0]    ones_seg;

  seven_segment u_decode (
    .number     (disp),
    .tens_digit (tens_seg),
    .ones_digit (ones_seg)
  );

  assign phase_last = ((state == TENS) || (state == ONES)) ? (cnt == LIT_LAST)
                                                           : (cnt == GAP_LAST);
  assign frame_edge = (state == GAP_O) && phase_last;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      if (state_next != state) cnt <= '0;
      else if (state != IDLE)  cnt <= cnt + CW'(1);
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (load)       state_next = TENS;
      TENS:    if (phase_last) state_next = GAP_T;
      GAP_T:   if (phase_last) state_next = ONES;
      ONES:    if (phase_last) state_next = GAP_O;
      GAP_O:   if (phase_last) state_next = TENS;
      default:                 state_next = IDLE;
    endcase
  end

  // New values only reach disp at a frame boundary; a load on that same edge wins over the shadow.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      disp       <= '0;
      shadow     <= '0;
      pending    <= 1'b0;
      blank_q    <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      blank_q    <= blank;
      frame_done <= frame_edge;
      if (state == IDLE) begin
        if (load) disp <= number;
      end else if (frame_edge) begin
        if (load)         disp <= number;
        else if (pending) disp <= shadow;
        pending <= 1'b0;
      end else if (load) begin
        shadow  <= number;
        pending <= 1'b1;
      end
    end
  end

  always_comb begin
    seg      = tens_seg;
    digit_en = 2'b00;
    case (state)
      TENS: begin
        seg = tens_seg;
`ifdef SEVEN_SEGMENT_SCANNER_LZS_EN
        digit_en = {~blank_q & (disp >= 5'd10), 1'b0};
`else
        digit_en = {~blank_q, 1'b0};
`endif
      end
      GAP_T:   seg = ones_seg;
      ONES: begin
        seg      = ones_seg;
        digit_en = {1'b0, ~blank_q};
      end
      default: seg = tens_seg;
    endcase
  end

endmodule
